// File: rtl/qsys_block_nios_oci_dct_packer.sv
// Nios OCI compressed-trace packer: 2-bit atoms into 30-bit frames, plus end-of-test sequencing.
// Optional dropped-atom counter port is enabled by defining QSYS_BLOCK_DCT_DROP_COUNT_EN.
module qsys_block_nios_oci_dct_packer #(
    parameter int unsigned AtomW = 2,
    parameter int unsigned Depth = 15,
    parameter int unsigned CntW  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   atom_valid_i,
    input  logic [AtomW-1:0]       atom_i,
    output logic                   atom_ready_o,
    input  logic                   flush_i,
    input  logic                   test_end_req_i,
    output logic [AtomW*Depth-1:0] dct_buffer_o,
    output logic [CntW-1:0]        dct_count_o,
    output logic                   frame_valid_o,
    input  logic                   frame_ready_i,
    output logic                   test_ending_o,
`ifdef QSYS_BLOCK_DCT_DROP_COUNT_EN
    output logic [15:0]            dct_drop_count_o,
`endif
    output logic                   test_has_ended_o
);

    localparam int unsigned BufW = AtomW * Depth;

    typedef enum logic [1:0] {StRun, StDrain, StEnding, StEnded} state_e;

    state_e          state_q, state_d;
    logic [BufW-1:0] acc_q, acc_d;
    logic [CntW-1:0] acc_cnt_q, acc_cnt_d;
    logic [BufW-1:0] out_buf_q, out_buf_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            frame_valid_q, frame_valid_d;
    logic            pend_q, pend_d;
    logic            rdy_en_q;

    logic            full, out_free, accept, flush_eff, close, transfer, drained;
    logic [BufW-1:0] frame_src, acc_rest;
    logic [CntW-1:0] frame_cnt, cnt_rest;

    always_comb begin
        full         = (acc_cnt_q == CntW'(Depth));
        out_free     = !frame_valid_q || frame_ready_i;
        atom_ready_o = rdy_en_q && (state_q == StRun) && !(full && !out_free);
        accept       = atom_valid_i && atom_ready_o;
        flush_eff    = flush_i || pend_q || (state_q == StDrain);

        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        frame_src = acc_q;
        frame_cnt = acc_cnt_q;
        acc_rest  = '0;
        cnt_rest  = '0;
        close     = 1'b0;

        if (full) begin
            // A full acc closes as-is; an atom accepted now starts the next frame.
            close = 1'b1;
            if (accept) begin
                acc_rest = {{(BufW-AtomW){1'b0}}, atom_i};
                cnt_rest = CntW'(1);
            end
        end else begin
            if (accept) begin
                acc_d     = {acc_q[BufW-AtomW-1:0], atom_i};
                acc_cnt_d = acc_cnt_q + CntW'(1);
            end
            frame_src = acc_d;
            frame_cnt = acc_cnt_d;
            close     = (acc_cnt_d == CntW'(Depth)) || (flush_eff && (acc_cnt_d != '0));
        end

        transfer = close && out_free;
        pend_d   = close && !transfer;
        if (transfer) begin
            acc_d     = acc_rest;
            acc_cnt_d = cnt_rest;
        end

        out_buf_d     = transfer ? frame_src : out_buf_q;
        out_cnt_d     = transfer ? frame_cnt : out_cnt_q;
        frame_valid_d = transfer || (frame_valid_q && !frame_ready_i);
    end

    always_comb begin
        drained = (acc_cnt_q == '0) && (!frame_valid_q || frame_ready_i);
        state_d = state_q;
        unique case (state_q)
            StRun:    if (test_end_req_i) state_d = (drained && !accept) ? StEnding : StDrain;
            StDrain:  if (drained) state_d = StEnding;
            StEnding: state_d = StEnded;
            StEnded:  state_d = StEnded;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StRun;
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            out_buf_q     <= '0;
            out_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            pend_q        <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            out_buf_q     <= out_buf_d;
            out_cnt_q     <= out_cnt_d;
            frame_valid_q <= frame_valid_d;
            pend_q        <= pend_d;
            rdy_en_q      <= 1'b1;
        end
    end

`ifdef QSYS_BLOCK_DCT_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (atom_valid_i && !atom_ready_o && (state_q == StRun) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign dct_drop_count_o = drop_q;
`endif

    assign dct_buffer_o     = out_buf_q;
    assign dct_count_o      = out_cnt_q;
    assign frame_valid_o    = frame_valid_q;
    assign test_ending_o    = (state_q == StEnding);
    assign test_has_ended_o = (state_q == StEnded);

endmodule

// File: tb/tb_qsys_block_nios_oci_dct_packer.sv
// Bench for the DCT packer: directed scenarios plus random traffic against an atom-stream model.
module tb_qsys_block_nios_oci_dct_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        atom_valid_i = 1'b0;
    logic [1:0]  atom_i = 2'b00;
    logic        atom_ready_o;
    logic        flush_i = 1'b0;
    logic        test_end_req_i = 1'b0;
    logic [29:0] dct_buffer_o;
    logic [3:0]  dct_count_o;
    logic        frame_valid_o;
    logic        frame_ready_i = 1'b0;
    logic        test_ending_o;
    logic        test_has_ended_o;
`ifdef QSYS_BLOCK_DCT_DROP_COUNT_EN
    logic [15:0] dct_drop_count_o;
`endif

    qsys_block_nios_oci_dct_packer dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .atom_valid_i     (atom_valid_i),
        .atom_i           (atom_i),
        .atom_ready_o     (atom_ready_o),
        .flush_i          (flush_i),
        .test_end_req_i   (test_end_req_i),
        .dct_buffer_o     (dct_buffer_o),
        .dct_count_o      (dct_count_o),
        .frame_valid_o    (frame_valid_o),
        .frame_ready_i    (frame_ready_i),
        .test_ending_o    (test_ending_o),
`ifdef QSYS_BLOCK_DCT_DROP_COUNT_EN
        .dct_drop_count_o (dct_drop_count_o),
`endif
        .test_has_ended_o (test_has_ended_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;

    // Model: every accepted atom in order; each taken frame must be the next slice of it.
    logic [1:0]  stream[$];
    int unsigned frames_taken = 0;
    int unsigned end_pulses = 0;
    int unsigned n_acc = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take_frame();
        logic [29:0] exp;
        int unsigned n;
        n = dct_count_o;
        check("frame_cnt_range", 36'((n >= 1) && (n <= 15)), 36'd1);
        check("frame_atoms_avail", 36'(stream.size() >= n), 36'd1);
        exp = '0;
        for (int i = 0; i < int'(n) && stream.size() > 0; i++) begin
            exp = {exp[27:0], stream.pop_front()};
        end
        check("frame_data", 36'(dct_buffer_o), 36'(exp));
        frames_taken++;
    endtask

    // One clock: drive at negedge, sample handshakes 1 time unit later, return at next negedge.
    task automatic cyc(input logic v, input logic [1:0] a, input logic fl, input logic fr,
                       input logic ter);
        logic acc_now;
        atom_valid_i = v; atom_i = a; flush_i = fl; frame_ready_i = fr; test_end_req_i = ter;
        #1;
        if (prev_stall) check("out_hold", {1'b0, frame_valid_o, dct_count_o, dct_buffer_o},
                              {2'b01, prev_out});
        prev_stall = frame_valid_o && !fr;
        prev_out   = {dct_count_o, dct_buffer_o};
        acc_now    = v && atom_ready_o;
        if (frame_valid_o && fr) take_frame();
        if (acc_now) begin
            stream.push_back(a);
            n_acc++;
        end
        if (test_ending_o) end_pulses++;
        @(negedge clk_i);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [29:0] exp;
        logic [1:0]  a;
        logic [29:0] f1;
        int unsigned base, fbase;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_ready", 36'(atom_ready_o), 36'd0);
        check("rst_out", {frame_valid_o, test_ending_o, test_has_ended_o, dct_count_o, dct_buffer_o},
              36'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1 check("ready_after_rst", 36'(atom_ready_o), 36'd1);

        // T1: 15 atoms back-to-back, frame 1 cycle after the 15th accept
        exp = '0;
        for (int i = 0; i < 15; i++) begin
            a = 2'((i + 1) % 4);
            exp = {exp[27:0], a};
            if (i == 14) check("t1_no_early_frame", 36'(frame_valid_o), 36'd0);
            cyc(1'b1, a, 1'b0, 1'b1, 1'b0);
        end
        check("t1_valid", 36'(frame_valid_o), 36'd1);
        check("t1_count", 36'(dct_count_o), 36'd15);
        check("t1_buffer", 36'(dct_buffer_o), 36'(exp));
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t1_taken", {1'b0, frame_valid_o, dct_count_o, dct_buffer_o}, {2'b00, 4'd15, exp});

        // T2: partial frame via flush; flush on empty acc emits nothing
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check("t2_valid", 36'(frame_valid_o), 36'd1);
        check("t2_frame", {dct_count_o, dct_buffer_o}, {4'd3, 30'h0000_0039});
        cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        check("t2_no_frame", 36'(frame_valid_o), 36'd0);

        // T3: stall the sink, fill output and acc, then release for back-to-back frames
        base = n_acc;
        fbase = frames_taken;
        f1 = '0;
        for (int i = 0; i < 40 && (n_acc - base) < 30; i++) begin
            a = 2'($urandom_range(0, 3));
            if ((n_acc - base) < 15) f1 = {f1[27:0], a};
            cyc(1'b1, a, 1'b0, 1'b0, 1'b0);
        end
        check("t3_accepts", 36'(n_acc - base), 36'd30);
        check("t3_ready_low", 36'(atom_ready_o), 36'd0);
        check("t3_frame1_held", {dct_count_o, dct_buffer_o}, {4'd15, f1});
        for (int i = 0; i < 20; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        check("t3_no_accept_stalled", 36'(n_acc - base), 36'd30);
`ifdef QSYS_BLOCK_DCT_DROP_COUNT_EN
        check("t5_drop_count", 36'(dct_drop_count_o), 36'd20);
`endif
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t3_b2b_valid", {frame_valid_o, dct_count_o}, {1'b1, 4'd15});
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t3_frames", 36'(frames_taken - fbase), 36'd2);
        for (int i = 0; i < 15; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t3_all_frames", 36'(frames_taken - fbase), 36'd3);

        // T6: asynchronous reset mid-frame
        for (int i = 0; i < 20; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        check("t6_pre_valid", 36'(frame_valid_o), 36'd1);
        #3 rst_ni = 1'b0;
        #1;
        check("t6_async", {atom_ready_o, frame_valid_o, dct_count_o, dct_buffer_o}, 36'd0);
        stream.delete();
        prev_stall = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        check("t6_post_frame", {dct_count_o, dct_buffer_o}, {4'd2, 30'h0000_0009});
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        check("rand_drained", 36'(stream.size()), 36'd0);
        check("rand_no_valid", 36'(frame_valid_o), 36'd0);

        // T4: end of test with a stalled output frame and 7 atoms in the accumulator
        fbase = frames_taken;
        for (int i = 0; i < 22; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("t4_ready_low", 36'(atom_ready_o), 36'd0);
        base = n_acc;
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        check("t4_no_accept", 36'(n_acc - base), 36'd0);
        check("t4_not_ended", 36'({test_ending_o, test_has_ended_o}), 36'd0);
        end_pulses = 0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("t4_frames", 36'(frames_taken - fbase), 36'd2);
        check("t4_end_pulse", 36'(end_pulses), 36'd1);
        check("t4_has_ended", 36'({test_ending_o, test_has_ended_o}), 36'd1);
        check("t4_stream_empty", 36'(stream.size()), 36'd0);
        base = n_acc;
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        check("t4_ended_refuses", 36'(n_acc - base), 36'd0);
        check("t4_sticky", 36'({atom_ready_o, test_has_ended_o, frame_valid_o}), 36'b010);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
